imm_field_encoder: RTL and testbench

- Inverse of the core's immediate decode path: packs a 32-bit immediate into the RISC-V I/S/B/J/U bit positions of a base instruction word.
- Checks that the immediate is representable in the chosen format.
- Two-stage valid/ready pipeline; sits between the self-test/boot-image instruction builder and instruction memory write port.
- Also feeds round-trip checks against the decode path.

---
 rtl/riscv_imm_pkg.sv | 31 +++
 rtl/imm_pack.sv | 67 ++++++
 rtl/imm_field_encoder.sv | 106 ++++++++++
 tb/tb_imm_field_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_imm_pkg
// Brief    : Immediate-format selectors shared with the decode path, plus
//            opcode constants and a sign-extension range helper.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_imm_pkg;

    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_U = 3'b101;

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    // True when imm[31:bits-1] are all equal, i.e. imm is a sign extension
    // of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] imm, input int unsigned bits);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (bits - 1);
        return ((imm & m) == m) || ((imm & m) == 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
// Module   : imm_pack
// Brief    : Combinational packer - scatters an immediate into the I/S/B/J/U
//            fields of a base instruction word and flags unrepresentable values.
// Revision : 1.0 - initial release
// ============================================================================
module imm_pack
    import riscv_imm_pkg::*;
#(
    parameter int CHECK_EN = 1
)(
    input  logic [31:0] i_base,
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_imm_src,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic [31:0] w_instr;
    logic        w_range_err;
    logic        w_illegal;

    always_comb begin
        w_instr     = i_base;
        w_range_err = 1'b0;
        w_illegal   = 1'b0;
        case (i_imm_src)
            IMM_I: begin
                w_instr[31:20] = i_imm[11:0];
                w_range_err    = !fits_signed(i_imm, 12);
            end
            IMM_S: begin
                w_instr[31:25] = i_imm[11:5];
                w_instr[11:7]  = i_imm[4:0];
                w_range_err    = !fits_signed(i_imm, 12);
            end
            IMM_B: begin
                w_instr[31]    = i_imm[12];
                w_instr[7]     = i_imm[11];
                w_instr[30:25] = i_imm[10:5];
                w_instr[11:8]  = i_imm[4:1];
                w_range_err    = !fits_signed(i_imm, 13) || i_imm[0];
            end
            IMM_J: begin
                w_instr[31]    = i_imm[20];
                w_instr[19:12] = i_imm[19:12];
                w_instr[20]    = i_imm[11];
                w_instr[30:21] = i_imm[10:1];
                w_range_err    = !fits_signed(i_imm, 21) || i_imm[0];
            end
            IMM_U: begin
                w_instr[31:12] = i_imm[31:12];
                w_range_err    = (i_imm[11:0] != 12'h000);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // An unknown format is always reported, even with range checking disabled.
    assign o_instr = w_instr;
    assign o_err   = w_illegal || ((CHECK_EN != 0) && w_range_err);

endmodule
`default_nettype wire

// File: rtl/imm_field_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_field_encoder
// Brief    : Two-stage valid/ready pipeline around imm_pack with a saturating
//            count of errored results delivered downstream.
// Revision : 1.0 - initial release
// ============================================================================
module imm_field_encoder
    import riscv_imm_pkg::*;
#(
    parameter int COUNT_W  = 16,
    parameter int CHECK_EN = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_base,
    input  logic [31:0]        in_imm,
    input  logic [2:0]         in_imm_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    input  logic               err_clr,
    output logic [COUNT_W-1:0] err_count
);

    localparam logic [COUNT_W-1:0] c_cnt_max = '1;
    localparam logic [COUNT_W-1:0] c_cnt_one = COUNT_W'(1);

    logic [31:0]        w_enc_instr;
    logic               w_enc_err;
    logic               w_s2_free;
    logic               w_s1_free;
    logic               w_out_fire;

    logic               r_s1_valid;
    logic [31:0]        r_s1_instr;
    logic               r_s1_err;
    logic               r_out_valid;
    logic [31:0]        r_out_instr;
    logic               r_out_err;
    logic [COUNT_W-1:0] r_err_count;

    imm_pack #(
        .CHECK_EN (CHECK_EN)
    ) u_pack (
        .i_base    (in_base),
        .i_imm     (in_imm),
        .i_imm_src (in_imm_src),
        .o_instr   (w_enc_instr),
        .o_err     (w_enc_err)
    );

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign w_out_fire = r_out_valid && out_ready;
    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_s1_free  = !r_s1_valid || w_s2_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= 32'h0;
            r_s1_err   <= 1'b0;
        end else if (w_s1_free) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_instr <= w_enc_instr;
                r_s1_err   <= w_enc_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
            r_out_err   <= 1'b0;
        end else if (w_s2_free) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_instr <= r_s1_instr;
                r_out_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_out_fire && r_out_err && (r_err_count != c_cnt_max)) begin
            r_err_count <= r_err_count + c_cnt_one;
        end
    end

    assign in_ready  = w_s1_free;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_field_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_field_encoder
// Brief    : Directed and randomized self-checking bench with a queue-based
//            reference model of the encoder pipeline and error counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_field_encoder;

    localparam int COUNT_W = 2;
    localparam logic [COUNT_W-1:0] c_max = '1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_base = 32'h0;
    logic [31:0]        in_imm = 32'h0;
    logic [2:0]         in_imm_src = 3'b000;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_instr;
    logic               out_err;
    logic               err_clr = 1'b0;
    logic [COUNT_W-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    imm_field_encoder #(
        .COUNT_W  (COUNT_W),
        .CHECK_EN (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_imm     (in_imm),
        .in_imm_src (in_imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: field placement and representable ranges straight from the format rules.
    function automatic logic [32:0] model(input logic [31:0] b, input logic [31:0] imm, input logic [2:0] s);
        logic [31:0] r;
        bit          e;
        longint      v;
        r = b;
        e = 1'b0;
        v = longint'($signed(imm));
        case (s)
            3'd1: begin r[31:20] = imm[11:0]; e = (v < -2048) || (v > 2047); end
            3'd2: begin r[31:25] = imm[11:5]; r[11:7] = imm[4:0]; e = (v < -2048) || (v > 2047); end
            3'd3: begin
                r[31] = imm[12]; r[7] = imm[11]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1];
                e = (v < -4096) || (v > 4095) || (v % 2 != 0);
            end
            3'd4: begin
                r[31] = imm[20]; r[19:12] = imm[19:12]; r[20] = imm[11]; r[30:21] = imm[10:1];
                e = (v < -1048576) || (v > 1048575) || (v % 2 != 0);
            end
            3'd5: begin r[31:12] = imm[31:12]; e = (imm % 4096) != 0; end
            default: begin r = b; e = 1'b1; end
        endcase
        return {e, r};
    endfunction

    logic [32:0]        q[$];
    logic [COUNT_W-1:0] m_cnt = '0;
    bit                 prev_stall = 1'b0;
    logic [31:0]        prev_instr = 32'h0;
    logic               prev_err = 1'b0;

    // Compare process: everything sampled on the falling edge, applying to the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt      = '0;
            prev_stall = 1'b0;
            check(out_valid == 1'b0, "mon_rst_valid", 32'(out_valid), 32'h0);
        end else begin
            check(err_count == m_cnt, "mon_err_count", 32'(err_count), 32'(m_cnt));
            if (prev_stall) begin
                check(out_valid == 1'b1, "mon_hold_valid", 32'(out_valid), 32'h1);
                check(out_instr == prev_instr && out_err == prev_err, "mon_hold_data", out_instr, prev_instr);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check(1'b0, "mon_unexpected_out", out_instr, 32'h0);
                end else begin
                    check(out_instr == q[0][31:0], "mon_instr", out_instr, q[0][31:0]);
                    check(out_err == q[0][32], "mon_err", 32'(out_err), 32'(q[0][32]));
                end
            end
            if (err_clr)
                m_cnt = '0;
            else if (out_valid && out_ready && q.size() != 0 && q[0][32] && m_cnt != c_max)
                m_cnt = m_cnt + 1'b1;
            if (out_valid && out_ready && q.size() != 0)
                void'(q.pop_front());
            if (in_valid && in_ready)
                q.push_back(model(in_base, in_imm, in_imm_src));
            prev_stall = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_err   = out_err;
        end
    end

    task automatic send(input logic [31:0] b, input logic [31:0] imm, input logic [2:0] s);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_base = b; in_imm = imm; in_imm_src = s;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check(1'b0, "send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [31:0] b, input logic [31:0] imm, input logic [2:0] s,
                            input logic [31:0] exp_i, input logic exp_e, input logic [COUNT_W-1:0] exp_cnt);
        send(b, imm, s);
        @(negedge clk);
        check(out_valid == 1'b0, {nm, "_early"}, 32'(out_valid), 32'h0);
        @(negedge clk);
        check(out_valid == 1'b1, {nm, "_valid"}, 32'(out_valid), 32'h1);
        check(out_instr == exp_i, {nm, "_instr"}, out_instr, exp_i);
        check(out_err == exp_e, {nm, "_err"}, 32'(out_err), 32'(exp_e));
        @(negedge clk);
        check(err_count == exp_cnt, {nm, "_cnt"}, 32'(err_count), 32'(exp_cnt));
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] imm;
        bit          acc;

        // Reset values while rst_n is held low.
        #12;
        check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'h0);
        check(out_instr == 32'h0, "rst_out_instr", out_instr, 32'h0);
        check(out_err == 1'b0, "rst_out_err", 32'(out_err), 32'h0);
        check(err_count == '0, "rst_err_count", 32'(err_count), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'h1);

        directed("i_neg",   32'h0000_0013, 32'hFFFF_F800, 3'b001, 32'h8000_0013, 1'b0, 2'd0);
        directed("b_max",   32'h0000_0063, 32'h0000_0FFE, 3'b011, 32'h7E00_0FE3, 1'b0, 2'd0);
        directed("b_odd",   32'h0000_0063, 32'h0000_0003, 3'b011, 32'h0000_0163, 1'b1, 2'd1);
        directed("j_neg2",  32'h0000_006F, 32'hFFFF_FFFE, 3'b100, 32'hFFFF_F06F, 1'b0, 2'd1);
        directed("j_ovf",   32'h0000_006F, 32'h0010_0000, 3'b100, 32'h8000_006F, 1'b1, 2'd2);
        directed("u_ok",    32'h0000_0037, 32'h1234_5000, 3'b101, 32'h1234_5037, 1'b0, 2'd2);
        directed("u_low",   32'h0000_0037, 32'h1234_5001, 3'b101, 32'h1234_5037, 1'b1, 2'd3);
        directed("illegal", 32'hDEAD_BEEF, 32'h0000_0000, 3'b110, 32'hDEAD_BEEF, 1'b1, 2'd3);
        directed("s_ovf",   32'h0000_0023, 32'h0000_0800, 3'b010, 32'h8000_0023, 1'b1, 2'd3);

        // err_clr coincides with an errored transfer: clear wins.
        send(32'h1234_5678, 32'h0, 3'b111);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check(err_count == '0, "clr_priority", 32'(err_count), 32'h0);

        // Backpressure: three back-to-back requests against a stalled output.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_base = 32'h13; in_imm = 32'h1; in_imm_src = 3'b001;
        @(negedge clk);
        check(in_ready == 1'b1, "bp_acc_a", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_imm = 32'h2;
        @(negedge clk);
        check(in_ready == 1'b1, "bp_acc_b", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_imm = 32'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(in_ready == 1'b0, "bp_full", 32'(in_ready), 32'h0);
            check(out_valid == 1'b1 && out_instr == 32'h0010_0013, "bp_hold_a", out_instr, 32'h0010_0013);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "bp_release_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b1 && out_instr == 32'h0020_0013, "bp_out_b", out_instr, 32'h0020_0013);
        @(negedge clk);
        check(out_valid == 1'b1 && out_instr == 32'h0030_0013, "bp_out_c", out_instr, 32'h0030_0013);
        @(negedge clk);
        check(out_valid == 1'b0, "bp_drained", 32'(out_valid), 32'h0);

        // Asynchronous reset with both stages full and a nonzero counter.
        directed("pre_rst", 32'h0, 32'h0, 3'b000, 32'h0, 1'b1, 2'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h13, 32'h7, 3'b001);
        send(32'h13, 32'h8, 3'b001);
        @(negedge clk);
        check(out_valid == 1'b1, "rst_pre_full", 32'(out_valid), 32'h1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "rst_async_valid", 32'(out_valid), 32'h0);
        check(err_count == '0, "rst_async_cnt", 32'(err_count), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "rst_no_stale", 32'(out_valid), 32'h0);
        end

        // Randomized traffic with random backpressure and occasional clears.
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                r = $urandom;
                case ($urandom_range(0, 5))
                    0: imm = r;
                    1: imm = {{20{r[11]}}, r[11:0]};
                    2: imm = {{19{r[12]}}, r[12:1], 1'b0};
                    3: imm = {{11{r[20]}}, r[20:1], 1'b0};
                    4: imm = {r[31:12], 12'h000};
                    default: imm = {{19{r[12]}}, r[12:0]} ^ (32'h1 << $urandom_range(0, 31));
                endcase
                in_imm     = imm;
                in_base    = $urandom;
                in_imm_src = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(q.size() == 0, "final_drain", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
